pixel_dequantizer: RTL and testbench

Streaming inverse of the pixel normalize/quantize path. Takes quantized 8-bit codes (valid/ready), removes a zero point, rescales them to unsigned Q0.32 normalized values, and re-derives an 8-bit pixel for debug/display. It sits between the quantized feature/pixel buffers and any consumer that needs Q0.32 data (reference model compare, layer inputs needing float-like range). It also generates frame boundaries and checks frame length.

---
 rtl/pixel_dequantizer_if.sv | 23 ++
 rtl/pixel_dequantizer.sv | 144 ++++++++++++++
 tb/tb_pixel_dequantizer.sv | 357 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pixel_dequantizer_if.sv
// rtl/pixel_dequantizer_if.sv - quantized-code input stream and Q0.32 output stream
interface pixel_dequantizer_if;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_last;
    logic        in_ready;
    logic [31:0] out_data;
    logic [7:0]  out_pixel;
    logic        out_sat;
    logic        out_last;
    logic        out_valid;
    logic        out_ready;

    modport master (
        output in_data, in_valid, in_last, out_ready,
        input  in_ready, out_data, out_pixel, out_sat, out_last, out_valid
    );

    modport slave (
        input  in_data, in_valid, in_last, out_ready,
        output in_ready, out_data, out_pixel, out_sat, out_last, out_valid
    );
endinterface

// File: rtl/pixel_dequantizer.sv
// rtl/pixel_dequantizer.sv - zero-point removal, Q0.32 rescale with saturation, frame counting
module pixel_dequantizer #(
    parameter int          FRAME_PIXELS = 51529,
    parameter int          CNT_W        = 16,
    parameter logic [31:0] RST_SCALE    = 32'h01010101,
    parameter logic [7:0]  RST_ZP       = 8'd0
) (
    input  logic                clk,
    input  logic                rstn,
    pixel_dequantizer_if.slave  s,
    input  logic                cfg_we,
    input  logic [31:0]         cfg_scale,
    input  logic [7:0]          cfg_zp,
    output logic                err_len,
    input  logic                err_clr
);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_PIXELS - 1);

    logic               en;
    logic               accept;
    logic               at_first;
    logic               at_last;
    logic [CNT_W-1:0]   count;

    logic [31:0]        scale_active;
    logic [31:0]        scale_shadow;
    logic [31:0]        scale_beat;
    logic [7:0]         zp_active;
    logic [7:0]         zp_shadow;
    logic [7:0]         zp_beat;
    logic               pending;

    logic               s1_valid;
    logic               s1_last;
    logic signed [8:0]  s1_diff;
    logic [31:0]        s1_scale;
    logic               s2_valid;
    logic               s2_last;
    logic signed [40:0] s2_prod;
    logic signed [40:0] prod;

    logic [31:0]        out_data_r;
    logic               out_sat_r;
    logic               out_last_r;
    logic               out_valid_r;

    assign en         = ~out_valid_r | s.out_ready;
    assign s.in_ready = rstn & en;
    assign accept     = s.in_valid & s.in_ready;
    assign at_first   = (count == '0);
    assign at_last    = (count == LAST_IDX);

    // The first beat of a frame picks up a pending (or same-cycle) config;
    // the chosen scale travels with the beat so a later commit cannot leak
    // into beats still in flight.
    always_comb begin
        scale_beat = scale_active;
        zp_beat    = zp_active;
        if (at_first) begin
            if (cfg_we) begin
                scale_beat = cfg_scale;
                zp_beat    = cfg_zp;
            end else if (pending) begin
                scale_beat = scale_shadow;
                zp_beat    = zp_shadow;
            end
        end
    end

    assign prod = $signed({{32{s1_diff[8]}}, s1_diff}) * $signed({9'd0, s1_scale});

    always_ff @(posedge clk) begin
        if (!rstn) begin
            count        <= '0;
            scale_active <= RST_SCALE;
            scale_shadow <= RST_SCALE;
            zp_active    <= RST_ZP;
            zp_shadow    <= RST_ZP;
            pending      <= 1'b0;
            err_len      <= 1'b0;
            s1_valid     <= 1'b0;
            s1_last      <= 1'b0;
            s1_diff      <= '0;
            s1_scale     <= '0;
            s2_valid     <= 1'b0;
            s2_last      <= 1'b0;
            s2_prod      <= '0;
            out_data_r   <= '0;
            out_sat_r    <= 1'b0;
            out_last_r   <= 1'b0;
            out_valid_r  <= 1'b0;
        end else begin
            if (cfg_we) begin
                scale_shadow <= cfg_scale;
                zp_shadow    <= cfg_zp;
                pending      <= 1'b1;
            end
            if (accept) begin
                count <= at_last ? '0 : count + CNT_W'(1);
                if (at_first && (cfg_we || pending)) begin
                    scale_active <= scale_beat;
                    zp_active    <= zp_beat;
                    pending      <= 1'b0;
                end
            end

            if (accept && (s.in_last != at_last)) begin
                err_len <= 1'b1;
            end else if (err_clr) begin
                err_len <= 1'b0;
            end

            if (en) begin
                s1_valid <= accept;
                s1_last  <= at_last;
                s1_diff  <= 9'({1'b0, s.in_data} - {1'b0, zp_beat});
                s1_scale <= scale_beat;

                s2_valid <= s1_valid;
                s2_last  <= s1_last;
                s2_prod  <= prod;

                out_valid_r <= s2_valid;
                out_last_r  <= s2_last;
                if (s2_prod[40]) begin
                    out_data_r <= 32'h0000_0000;
                    out_sat_r  <= 1'b1;
                end else if (|s2_prod[39:32]) begin
                    out_data_r <= 32'hFFFF_FFFF;
                    out_sat_r  <= 1'b1;
                end else begin
                    out_data_r <= s2_prod[31:0];
                    out_sat_r  <= 1'b0;
                end
            end
        end
    end

    assign s.out_data  = out_data_r;
    assign s.out_pixel = out_data_r[31:24];
    assign s.out_sat   = out_sat_r;
    assign s.out_last  = out_last_r;
    assign s.out_valid = out_valid_r;
endmodule

// File: tb/tb_pixel_dequantizer.sv
// tb/tb_pixel_dequantizer.sv - table vectors, directed sequences and random scoreboard for pixel_dequantizer
module tb_pixel_dequantizer;
    localparam int FP = 4;

    logic        clk = 1'b0;
    logic        rstn;
    logic        cfg_we;
    logic [31:0] cfg_scale;
    logic [7:0]  cfg_zp;
    logic        err_len;
    logic        err_clr;

    always #5 clk = ~clk;

    pixel_dequantizer_if bus();

    pixel_dequantizer #(
        .FRAME_PIXELS(FP),
        .CNT_W(16),
        .RST_SCALE(32'h01010101),
        .RST_ZP(8'd0)
    ) dut (
        .clk(clk),
        .rstn(rstn),
        .s(bus),
        .cfg_we(cfg_we),
        .cfg_scale(cfg_scale),
        .cfg_zp(cfg_zp),
        .err_len(err_len),
        .err_clr(err_clr)
    );

    typedef struct {
        logic [31:0] data;
        logic        sat;
        logic        last;
        int          cyc;
    } beat_t;

    typedef struct {
        logic [7:0]  zp;
        logic [31:0] scale;
        logic [7:0]  code;
        logic [31:0] exp;
        logic        sat;
    } vec_t;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    beat_t sb[$];
    beat_t got[$];

    int          cnt_m;
    logic [31:0] sc_act, sc_sh;
    logic [7:0]  zp_act, zp_sh;
    bit          pend_m;
    bit          err_m;
    bit          prev_stall;
    logic [63:0] held;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic beat_t expect_beat(input logic [7:0] code, input logic [7:0] zp,
                                          input logic [31:0] sc, input bit last, input int c);
        beat_t  b;
        longint v;
        v = (longint'(code) - longint'(zp)) * longint'(sc);
        if (v < 0) begin
            b.data = 32'h0; b.sat = 1'b1;
        end else if (v > 64'hFFFF_FFFF) begin
            b.data = 32'hFFFF_FFFF; b.sat = 1'b1;
        end else begin
            b.data = v[31:0]; b.sat = 1'b0;
        end
        b.last = last;
        b.cyc  = c;
        return b;
    endfunction

    // Reference model: frame-level config selection and a queue of expected beats.
    always @(negedge clk) begin
        beat_t e, g;
        bit    acc, first, lst, set;
        if (!rstn) begin
            cnt_m = 0; sc_act = 32'h01010101; sc_sh = 32'h01010101;
            zp_act = 8'd0; zp_sh = 8'd0; pend_m = 0; err_m = 0;
            prev_stall = 0;
            sb.delete();
        end else begin
            check("in_ready", {63'd0, bus.in_ready}, {63'd0, (!bus.out_valid || bus.out_ready)});
            check("err_len", {63'd0, err_len}, {63'd0, err_m});
            if (prev_stall) begin
                check("hold_valid", {63'd0, bus.out_valid}, 64'd1);
                check("hold_data", {22'd0, bus.out_data, bus.out_pixel, bus.out_sat, bus.out_last}, held);
            end
            if (bus.out_valid && bus.out_ready) begin
                if (sb.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_out: got %0h expected none", bus.out_data);
                end else begin
                    e = sb.pop_front();
                    check("out_data", {32'd0, bus.out_data}, {32'd0, e.data});
                    check("out_pixel", {56'd0, bus.out_pixel}, {56'd0, e.data[31:24]});
                    check("out_sat", {63'd0, bus.out_sat}, {63'd0, e.sat});
                    check("out_last", {63'd0, bus.out_last}, {63'd0, e.last});
                end
                g.data = bus.out_data; g.sat = bus.out_sat; g.last = bus.out_last; g.cyc = cyc;
                got.push_back(g);
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            held = {22'd0, bus.out_data, bus.out_pixel, bus.out_sat, bus.out_last};

            acc   = bus.in_valid && bus.in_ready;
            first = (cnt_m == 0);
            lst   = (cnt_m == FP - 1);
            set   = 0;
            if (acc && first) begin
                if (cfg_we) begin
                    sc_act = cfg_scale; zp_act = cfg_zp; sc_sh = cfg_scale; zp_sh = cfg_zp; pend_m = 0;
                end else if (pend_m) begin
                    sc_act = sc_sh; zp_act = zp_sh; pend_m = 0;
                end
            end else if (cfg_we) begin
                sc_sh = cfg_scale; zp_sh = cfg_zp; pend_m = 1;
            end
            if (acc) begin
                sb.push_back(expect_beat(bus.in_data, zp_act, sc_act, lst, cyc));
                if (bus.in_last != lst) set = 1;
                cnt_m = (cnt_m + 1) % FP;
            end
            if (set) err_m = 1;
            else if (err_clr) err_m = 0;
        end
    end

    task automatic send(input logic [7:0] code, input bit last, output int ac);
        bit done;
        done = 0;
        ac = -1;
        bus.in_data = code; bus.in_valid = 1'b1; bus.in_last = last;
        for (int k = 0; k < 200 && !done; k++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                done = 1;
                ac = cyc;
            end
            @(posedge clk); #1;
        end
        if (!done) begin
            total++; bad++;
            $display("FAIL send_timeout: got no accept expected accept of %0h", code);
        end
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic do_cfg(input logic [31:0] sc, input logic [7:0] zp);
        cfg_scale = sc; cfg_zp = zp; cfg_we = 1'b1;
        @(posedge clk); #1;
        cfg_we = 1'b0;
    endtask

    task automatic drain();
        int k;
        k = 0;
        while ((sb.size() != 0 || bus.out_valid) && k < 100) begin
            @(posedge clk); #1;
            k++;
        end
        if (sb.size() != 0) begin
            total++; bad++;
            $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    vec_t tbl[8];
    int   ac;
    logic [1:0] ready_pat [4];

    initial begin
        rstn = 1'b0; cfg_we = 1'b0; cfg_scale = 32'h0; cfg_zp = 8'h0; err_clr = 1'b0;
        bus.in_data = 8'h0; bus.in_valid = 1'b0; bus.in_last = 1'b0; bus.out_ready = 1'b1;
        cycles(3);

        check("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
        check("rst_out_data", {32'd0, bus.out_data}, 64'd0);
        check("rst_out_pixel", {56'd0, bus.out_pixel}, 64'd0);
        check("rst_out_sat", {63'd0, bus.out_sat}, 64'd0);
        check("rst_out_last", {63'd0, bus.out_last}, 64'd0);
        check("rst_err_len", {63'd0, err_len}, 64'd0);
        check("rst_in_ready", {63'd0, bus.in_ready}, 64'd0);
        rstn = 1'b1;
        cycles(1);

        tbl[0] = '{8'd0,  32'h01010101, 8'd0,   32'h00000000, 1'b0};
        tbl[1] = '{8'd0,  32'h01010101, 8'd1,   32'h01010101, 1'b0};
        tbl[2] = '{8'd0,  32'h01010101, 8'd128, 32'h80808080, 1'b0};
        tbl[3] = '{8'd0,  32'h01010101, 8'd255, 32'hFFFFFFFF, 1'b0};
        tbl[4] = '{8'd10, 32'h02000000, 8'd5,   32'h00000000, 1'b1};
        tbl[5] = '{8'd10, 32'h02000000, 8'd10,  32'h00000000, 1'b0};
        tbl[6] = '{8'd10, 32'h02000000, 8'd200, 32'hFFFFFFFF, 1'b1};
        tbl[7] = '{8'd10, 32'h02000000, 8'd11,  32'h02000000, 1'b0};
        for (int i = 0; i < 8; i++) begin
            if (i % 4 == 0) do_cfg(tbl[i].scale, tbl[i].zp);
            got.delete();
            send(tbl[i].code, (i % 4) == 3, ac);
            idle();
            drain();
            if (got.size() == 1) begin
                check($sformatf("tbl%0d_data", i), {32'd0, got[0].data}, {32'd0, tbl[i].exp});
                check($sformatf("tbl%0d_sat", i), {63'd0, got[0].sat}, {63'd0, tbl[i].sat});
                check($sformatf("tbl%0d_latency", i), 64'(got[0].cyc - ac), 64'd3);
            end else begin
                total++; bad++;
                $display("FAIL tbl%0d_count: got %0d expected 1", i, got.size());
            end
        end

        // Backpressure: out_ready cycles 1,0,0,1 while eight codes stream in.
        ready_pat[0] = 2'd1; ready_pat[1] = 2'd0; ready_pat[2] = 2'd0; ready_pat[3] = 2'd1;
        got.delete();
        fork
            begin
                for (int k = 0; k < 8; k++) send(8'(10 + k), (k % 4) == 3, ac);
                idle();
            end
            begin
                for (int k = 0; k < 60; k++) begin
                    bus.out_ready = ready_pat[k % 4][0];
                    @(posedge clk); #1;
                end
            end
        join
        bus.out_ready = 1'b1;
        drain();
        check("bp_count", 64'(got.size()), 64'd8);
        for (int k = 0; k < 8 && k < got.size(); k++)
            check($sformatf("bp_order%0d", k), {32'd0, got[k].data}, {32'd0, 32'(k) << 25});

        // Framing and length error.
        got.delete();
        for (int k = 0; k < 8; k++) send(8'(20 + k), (k % 4) == 3, ac);
        idle();
        drain();
        check("frame_err_clean", {63'd0, err_len}, 64'd0);
        if (got.size() == 8) begin
            check("frame_last2", {63'd0, got[2].last}, 64'd0);
            check("frame_last3", {63'd0, got[3].last}, 64'd1);
            check("frame_last7", {63'd0, got[7].last}, 64'd1);
        end
        for (int k = 0; k < 4; k++) send(8'(30 + k), k == 2, ac);
        idle();
        drain();
        check("frame_err_set", {63'd0, err_len}, 64'd1);
        cycles(5);
        check("frame_err_sticky", {63'd0, err_len}, 64'd1);
        err_clr = 1'b1;
        cycles(1);
        err_clr = 1'b0;
        check("frame_err_clr", {63'd0, err_len}, 64'd0);

        // Mid-frame config waits for the next frame.
        got.delete();
        send(8'd10, 0, ac); send(8'd11, 0, ac);
        idle();
        do_cfg(32'h00010000, 8'd0);
        send(8'd12, 0, ac); send(8'd13, 1, ac);
        send(8'd2, 0, ac); send(8'd3, 0, ac); send(8'd4, 0, ac); send(8'd5, 1, ac);
        idle();
        drain();
        if (got.size() == 8) begin
            check("cfg_old_b2", {32'd0, got[2].data}, 64'h04000000);
            check("cfg_old_b3", {32'd0, got[3].data}, 64'h06000000);
            check("cfg_new_b4", {32'd0, got[4].data}, 64'h00020000);
            check("cfg_new_b5", {32'd0, got[5].data}, 64'h00030000);
        end else begin
            total++; bad++;
            $display("FAIL cfg_count: got %0d expected 8", got.size());
        end

        // Random traffic against the reference model.
        for (int k = 0; k < 800; k++) begin
            bus.out_ready = ($urandom_range(0, 3) != 0);
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.in_data   = 8'($urandom_range(0, 255));
            bus.in_last   = (cnt_m == FP - 1) ^ ($urandom_range(0, 15) == 0);
            cfg_we        = ($urandom_range(0, 39) == 0);
            cfg_scale     = $urandom;
            cfg_zp        = 8'($urandom_range(0, 255));
            err_clr       = ($urandom_range(0, 29) == 0);
            @(posedge clk); #1;
        end
        idle();
        cfg_we = 1'b0; err_clr = 1'b0; bus.out_ready = 1'b1;
        drain();

        // Reset with three beats in flight.
        rstn = 1'b0;
        cycles(1);
        rstn = 1'b1;
        do_cfg(32'h00010000, 8'd0);
        bus.out_ready = 1'b0;
        send(8'd5, 0, ac); send(8'd6, 1, ac); send(8'd7, 0, ac);
        idle();
        cycles(2);
        check("rst_mid_err_before", {63'd0, err_len}, 64'd1);
        check("rst_mid_valid_before", {63'd0, bus.out_valid}, 64'd1);
        rstn = 1'b0;
        cycles(1);
        check("rst_mid_valid", {63'd0, bus.out_valid}, 64'd0);
        check("rst_mid_err", {63'd0, err_len}, 64'd0);
        check("rst_mid_in_ready", {63'd0, bus.in_ready}, 64'd0);
        rstn = 1'b1;
        bus.out_ready = 1'b1;
        got.delete();
        for (int k = 0; k < 4; k++) send(8'd255, k == 3, ac);
        idle();
        drain();
        if (got.size() == 4) begin
            check("rst_post_data", {32'd0, got[0].data}, 64'hFFFFFFFF);
            check("rst_post_last0", {63'd0, got[0].last}, 64'd0);
            check("rst_post_last2", {63'd0, got[2].last}, 64'd0);
            check("rst_post_last3", {63'd0, got[3].last}, 64'd1);
        end else begin
            total++; bad++;
            $display("FAIL rst_post_count: got %0d expected 4", got.size());
        end
        check("rst_post_err", {63'd0, err_len}, 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
